// File: rtl/wrr_pkg.sv
// -----------------------------------------------------------------------------
// wrr_pkg
// Shared definitions for the weighted round-robin grant controller:
//   - default channel count and weight width
//   - the grant FSM state encoding
// -----------------------------------------------------------------------------
package wrr_pkg;

    localparam int unsigned WRR_CHANNELS_DEF = 8;
    localparam int unsigned WRR_WEIGHT_W_DEF = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } wrr_state_e;

endpackage : wrr_pkg

// File: rtl/wrr_prio_pick.sv
// -----------------------------------------------------------------------------
// wrr_prio_pick
// Fixed-priority picker: isolates the lowest-index set bit of a vector and
// reports its binary index. Purely combinational.
// Ports:
//   vec    in  WIDTH           candidate vector (may be zero or multi-hot)
//   onehot out WIDTH           lowest set bit of vec, zero if vec is zero
//   idx    out $clog2(WIDTH)   binary index of onehot, zero if vec is zero
// -----------------------------------------------------------------------------
module wrr_prio_pick #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [WIDTH-1:0]         onehot,
    output logic [$clog2(WIDTH)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] VEC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Two's-complement trick isolates the lowest set bit; the index is the
    // OR of the positions selected by the (at most one) set bit.
    always_comb begin
        onehot = vec & (~vec + VEC_ONE);
        idx    = {IDX_W{1'b0}};
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = idx | ({IDX_W{onehot[i]}} & IDX_W'(i));
        end
    end

endmodule : wrr_prio_pick

// File: rtl/wrr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// wrr_grant_ctrl
// Weighted round-robin grant controller. A granted channel keeps the grant for
// up to its effective weight (weight 0 counts as 1) while it keeps requesting;
// then the grant moves to the lowest-index other candidate offered by the
// external next-grant stage, or is renewed if the channel is the sole
// requester.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   req      in   CHANNELS           per-channel request level
//   next_gnt in   CHANNELS           candidate vector from the next-grant stage
//   weight   in   CHANNELS*WEIGHT_W  packed weights, channel i at [i*W +: W]
//   gnt      out  CHANNELS           registered one-hot / zero grant
//   gnt_id   out  $clog2(CHANNELS)   index of the granted channel, 0 if none
//   busy     out  1                  high while a grant is held
// -----------------------------------------------------------------------------
module wrr_grant_ctrl
    import wrr_pkg::*;
#(
    parameter int unsigned CHANNELS = WRR_CHANNELS_DEF,
    parameter int unsigned WEIGHT_W = WRR_WEIGHT_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            req,
    input  logic [CHANNELS-1:0]            next_gnt,
    input  logic [CHANNELS*WEIGHT_W-1:0]   weight,
    output logic [CHANNELS-1:0]            gnt,
    output logic [$clog2(CHANNELS)-1:0]    gnt_id,
    output logic                           busy
);

    localparam int unsigned IDX_W = $clog2(CHANNELS);
    localparam logic [WEIGHT_W-1:0] CREDIT_ONE  = {{(WEIGHT_W-1){1'b0}}, 1'b1};
    localparam logic [WEIGHT_W-1:0] CREDIT_ZERO = {WEIGHT_W{1'b0}};

    wrr_state_e             state_q, state_d;
    logic [CHANNELS-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]       gnt_id_q, gnt_id_d;
    logic                   busy_q, busy_d;
    logic [WEIGHT_W-1:0]    credit_q, credit_d;

    logic [CHANNELS-1:0]    cand_vec_s, cand_oh_s;
    logic [IDX_W-1:0]       cand_idx_s;
    logic [CHANNELS-1:0]    alt_vec_s, alt_oh_s;
    logic [IDX_W-1:0]       alt_idx_s;
    logic                   held_s;
    logic [WEIGHT_W-1:0]    wt_s [CHANNELS];

    // A zero weight still earns one cycle of grant.
    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == CREDIT_ZERO) ? CREDIT_ONE : w;
    endfunction

    // Unpack the weight bus and form the candidate vectors for both pickers.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            wt_s[i] = weight[i*WEIGHT_W +: WEIGHT_W];
        end
        cand_vec_s = next_gnt & req;
        alt_vec_s  = next_gnt & req & ~gnt_q;
        held_s     = |(req & gnt_q);
    end

    wrr_prio_pick #(.WIDTH(CHANNELS)) u_pick_cand (
        .vec    (cand_vec_s),
        .onehot (cand_oh_s),
        .idx    (cand_idx_s)
    );

    wrr_prio_pick #(.WIDTH(CHANNELS)) u_pick_alt (
        .vec    (alt_vec_s),
        .onehot (alt_oh_s),
        .idx    (alt_idx_s)
    );

    // Next-state and next-output logic of the grant FSM.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        credit_d = credit_q;
        case (state_q)
            IDLE: begin
                if (cand_oh_s != {CHANNELS{1'b0}}) begin
                    state_d  = GRANT;
                    gnt_d    = cand_oh_s;
                    gnt_id_d = cand_idx_s;
                    credit_d = eff_weight(wt_s[cand_idx_s]);
                end else begin
                    state_d  = IDLE;
                    gnt_d    = {CHANNELS{1'b0}};
                    gnt_id_d = {IDX_W{1'b0}};
                    credit_d = CREDIT_ZERO;
                end
            end
            GRANT: begin
                if (held_s && (credit_q > CREDIT_ONE)) begin
                    credit_d = credit_q - CREDIT_ONE;
                end else if (alt_oh_s != {CHANNELS{1'b0}}) begin
                    gnt_d    = alt_oh_s;
                    gnt_id_d = alt_idx_s;
                    credit_d = eff_weight(wt_s[alt_idx_s]);
                end else if (held_s) begin
                    // Sole requester: renew the same channel with fresh credit.
                    credit_d = eff_weight(wt_s[gnt_id_q]);
                end else begin
                    state_d  = IDLE;
                    gnt_d    = {CHANNELS{1'b0}};
                    gnt_id_d = {IDX_W{1'b0}};
                    credit_d = CREDIT_ZERO;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = {CHANNELS{1'b0}};
                gnt_id_d = {IDX_W{1'b0}};
                credit_d = CREDIT_ZERO;
            end
        endcase
        busy_d = (state_d == GRANT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= {CHANNELS{1'b0}};
            gnt_id_q <= {IDX_W{1'b0}};
            busy_q   <= 1'b0;
            credit_q <= CREDIT_ZERO;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            credit_q <= credit_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule : wrr_grant_ctrl
